// File: rtl/tlp_tx_scheduler.sv
// PCIe TX scheduler: round-robin MWr/MRd arbitration from FWFT FIFOs
// into a SOP/EOP beat stream, with TLP counters and overrun flag.
module tlp_tx_scheduler #(
  parameter int DATA_WIDTH        = 256,
  parameter int HDR_WIDTH         = 128,
  parameter int MAX_PAYLOAD_BEATS = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aw_empty_i,
  input  logic [HDR_WIDTH-1:0]  aw_rdata_i,
  output logic                  aw_rden_o,
  input  logic                  ar_empty_i,
  input  logic [HDR_WIDTH-1:0]  ar_rdata_i,
  output logic                  ar_rden_o,
  input  logic                  pw_empty_i,
  input  logic [DATA_WIDTH-1:0] pw_rdata_i,
  input  logic                  pw_last_i,
  output logic                  pw_rden_o,
  output logic                  tlp_valid_o,
  input  logic                  tlp_ready_i,
  output logic [DATA_WIDTH-1:0] tlp_data_o,
  output logic                  tlp_sop_o,
  output logic                  tlp_eop_o,
  output logic                  tlp_is_wr_o,
  output logic [CNT_WIDTH-1:0]  wr_tlp_cnt_o,
  output logic [CNT_WIDTH-1:0]  rd_tlp_cnt_o,
  output logic                  overrun_err_o
);

  localparam int BW = $clog2(MAX_PAYLOAD_BEATS + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_HDR  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_HDR  = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 rr_q, rr_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                 err_q, err_d;

  logic wr_req, rd_req, at_limit;

  assign wr_req   = !aw_empty_i && !pw_empty_i;
  assign rd_req   = !ar_empty_i;
  assign at_limit = (beat_q == BW'(MAX_PAYLOAD_BEATS - 1));

  assign wr_tlp_cnt_o  = wr_cnt_q;
  assign rd_tlp_cnt_o  = rd_cnt_q;
  assign overrun_err_o = err_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    beat_d      = beat_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    err_d       = err_q;
    aw_rden_o   = 1'b0;
    ar_rden_o   = 1'b0;
    pw_rden_o   = 1'b0;
    tlp_valid_o = 1'b0;
    tlp_data_o  = '0;
    tlp_sop_o   = 1'b0;
    tlp_eop_o   = 1'b0;
    tlp_is_wr_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req && (!rd_req || !rr_q)) begin
          state_d = S_WR_HDR;
          rr_d    = 1'b1;
        end else if (rd_req) begin
          state_d = S_RD_HDR;
          rr_d    = 1'b0;
        end
      end
      S_WR_HDR: begin
        tlp_valid_o = 1'b1;
        tlp_sop_o   = 1'b1;
        tlp_is_wr_o = 1'b1;
        tlp_data_o  = DATA_WIDTH'(aw_rdata_i);
        if (tlp_ready_i) begin
          aw_rden_o = 1'b1;
          beat_d    = '0;
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        tlp_valid_o = !pw_empty_i;
        tlp_is_wr_o = 1'b1;
        tlp_data_o  = pw_rdata_i;
        tlp_eop_o   = pw_last_i || at_limit;
        if (!pw_empty_i && tlp_ready_i) begin
          pw_rden_o = 1'b1;
          beat_d    = beat_q + BW'(1);
          if (tlp_eop_o) begin
            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
            // limit hit mid-burst: remaining beats must be discarded
            if (!pw_last_i) begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DRAIN: begin
        pw_rden_o = !pw_empty_i;
        if (!pw_empty_i && pw_last_i) state_d = S_IDLE;
      end
      S_RD_HDR: begin
        tlp_valid_o = 1'b1;
        tlp_sop_o   = 1'b1;
        tlp_eop_o   = 1'b1;
        tlp_data_o  = DATA_WIDTH'(ar_rdata_i);
        if (tlp_ready_i) begin
          ar_rden_o = 1'b1;
          rd_cnt_d  = rd_cnt_q + CNT_WIDTH'(1);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      aw_rden_o = 1'b0;
      ar_rden_o = 1'b0;
      pw_rden_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      beat_q   <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Scoreboard bench for tlp_tx_scheduler: FIFO models, random ready and
// payload gaps, transaction-level arbitration model.
module tb_tlp_tx_scheduler;
  localparam int DW  = 256;
  localparam int HW  = 128;
  localparam int MPB = 8;
  localparam int CW  = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
    logic          wr;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aw_empty_i, ar_empty_i, pw_empty_i, pw_last_i;
  logic [HW-1:0] aw_rdata_i, ar_rdata_i;
  logic [DW-1:0] pw_rdata_i;
  logic aw_rden_o, ar_rden_o, pw_rden_o;
  logic tlp_valid_o, tlp_ready_i, tlp_sop_o, tlp_eop_o, tlp_is_wr_o;
  logic [DW-1:0] tlp_data_o;
  logic [CW-1:0] wr_tlp_cnt_o, rd_tlp_cnt_o;
  logic overrun_err_o;

  tlp_tx_scheduler #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW),
    .MAX_PAYLOAD_BEATS(MPB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .aw_empty_i(aw_empty_i), .aw_rdata_i(aw_rdata_i), .aw_rden_o(aw_rden_o),
    .ar_empty_i(ar_empty_i), .ar_rdata_i(ar_rdata_i), .ar_rden_o(ar_rden_o),
    .pw_empty_i(pw_empty_i), .pw_rdata_i(pw_rdata_i),
    .pw_last_i(pw_last_i), .pw_rden_o(pw_rden_o),
    .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i),
    .tlp_data_o(tlp_data_o), .tlp_sop_o(tlp_sop_o), .tlp_eop_o(tlp_eop_o),
    .tlp_is_wr_o(tlp_is_wr_o), .wr_tlp_cnt_o(wr_tlp_cnt_o),
    .rd_tlp_cnt_o(rd_tlp_cnt_o), .overrun_err_o(overrun_err_o)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  logic [HW-1:0] aw_q[$];
  logic [HW-1:0] ar_q[$];
  logic [DW:0]   pw_q[$];

  int checks = 0;
  int errors = 0;
  int m_wr = 0;
  int m_rd = 0;
  bit m_err = 0;
  bit m_rr = 0;

  bit pop_aw, pop_ar, pop_pw;
  bit pw_start = 1;
  int hide_cnt = 0;
  bit bub_en = 0;
  bit rdy_rand = 0;
  int stall = 0;
  bit held = 0;
  beat_t held_b;

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [HW-1:0] rand_hw();
    logic [HW-1:0] v;
    for (int i = 0; i < HW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    aw_empty_i = (aw_q.size() == 0);
    aw_rdata_i = aw_empty_i ? '0 : aw_q[0];
    ar_empty_i = (ar_q.size() == 0);
    ar_rdata_i = ar_empty_i ? '0 : ar_q[0];
    pw_empty_i = (pw_q.size() == 0) || (hide_cnt > 0);
    pw_rdata_i = (pw_q.size() == 0) ? '0 : pw_q[0][DW-1:0];
    pw_last_i  = (pw_q.size() == 0) ? 1'b0 : pw_q[0][DW];
  endtask

  // FIFO model and ready driver, applied just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (pop_aw && aw_q.size() > 0) void'(aw_q.pop_front());
    if (pop_ar && ar_q.size() > 0) void'(ar_q.pop_front());
    if (pop_pw && pw_q.size() > 0) begin
      pw_start = pw_q[0][DW];
      void'(pw_q.pop_front());
      if (bub_en && !pw_start && pw_q.size() > 0)
        hide_cnt = $urandom_range(0, 4);
    end else if (hide_cnt > 0) begin
      hide_cnt--;
    end
    if (!rdy_rand) begin
      tlp_ready_i = 1'b1;
    end else if (stall > 0) begin
      tlp_ready_i = 1'b0;
      stall--;
    end else if ($urandom_range(0, 15) == 0) begin
      tlp_ready_i = 1'b0;
      stall = 4;
    end else begin
      tlp_ready_i = ($urandom_range(0, 3) != 0);
    end
    refresh();
  end

  // monitor: pops scoreboard on every accepted beat
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    pop_aw = aw_rden_o;
    pop_ar = ar_rden_o;
    pop_pw = pw_rden_o;
    if (aw_rden_o) check("aw_pop_nonempty", DW'(aw_empty_i), '0);
    if (pw_rden_o) check("pw_pop_nonempty", DW'(pw_empty_i), '0);
    cur = '{d: tlp_data_o, sop: tlp_sop_o, eop: tlp_eop_o, wr: tlp_is_wr_o};
    if (held) begin
      check("hold_valid", DW'(tlp_valid_o), DW'(1));
      check("hold_beat", DW'(cur), DW'(held_b));
    end
    held = !rst && tlp_valid_o && !tlp_ready_i;
    held_b = cur;
    if (!rst && tlp_valid_o && tlp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", cur);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", cur.d, e.d);
        check("beat_flags", DW'({cur.sop, cur.eop, cur.wr}),
              DW'({e.sop, e.eop, e.wr}));
      end
    end
  end

  // load nw writes and nr reads; len 0 picks a random burst length
  task automatic load(input int nw, input int nr, input int len);
    logic [HW-1:0] whd[$];
    int wlen[$];
    logic [DW-1:0] wdat[$];
    logic [HW-1:0] rhd[$];
    int wi = 0;
    int ri = 0;
    int l, n;
    for (int i = 0; i < nw; i++) begin
      whd.push_back(rand_hw());
      l = (len > 0) ? len : $urandom_range(1, 12);
      wlen.push_back(l);
      for (int k = 0; k < l; k++) wdat.push_back(rand_dw());
    end
    for (int i = 0; i < nr; i++) rhd.push_back(rand_hw());
    while (wi < nw || ri < nr) begin
      if (wi < nw && (ri >= nr || !m_rr)) begin
        exp_q.push_back('{d: {{(DW-HW){1'b0}}, whd[wi]},
                          sop: 1'b1, eop: 1'b0, wr: 1'b1});
        n = (wlen[wi] > MPB) ? MPB : wlen[wi];
        for (int k = 0; k < wlen[wi]; k++) begin
          if (k < n)
            exp_q.push_back('{d: wdat[0], sop: 1'b0,
                              eop: (k == n - 1), wr: 1'b1});
          pw_q.push_back({k == wlen[wi] - 1, wdat[0]});
          void'(wdat.pop_front());
        end
        if (wlen[wi] > MPB) m_err = 1;
        aw_q.push_back(whd[wi]);
        m_wr++;
        m_rr = 1;
        wi++;
      end else begin
        exp_q.push_back('{d: {{(DW-HW){1'b0}}, rhd[ri]},
                          sop: 1'b1, eop: 1'b1, wr: 1'b0});
        ar_q.push_back(rhd[ri]);
        m_rd++;
        m_rr = 0;
        ri++;
      end
    end
    refresh();
  endtask

  task automatic finish_batch(input string nm);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      done = (exp_q.size() == 0) && (aw_q.size() == 0) &&
             (ar_q.size() == 0) && (pw_q.size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats left expected 0",
               nm, exp_q.size());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({nm, "_wr_cnt"}, DW'(wr_tlp_cnt_o), DW'(CW'(m_wr)));
    check({nm, "_rd_cnt"}, DW'(rd_tlp_cnt_o), DW'(CW'(m_rd)));
    check({nm, "_overrun"}, DW'(overrun_err_o), DW'(m_err));
    check({nm, "_idle"}, DW'(tlp_valid_o), '0);
  endtask

  initial begin
    tlp_ready_i = 1'b1;
    refresh();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", DW'(tlp_valid_o), '0);
    check("rst_data", tlp_data_o, '0);
    check("rst_flags", DW'({tlp_sop_o, tlp_eop_o, tlp_is_wr_o}), '0);
    check("rst_rden", DW'({aw_rden_o, ar_rden_o, pw_rden_o}), '0);
    check("rst_cnts", DW'({wr_tlp_cnt_o, rd_tlp_cnt_o, overrun_err_o}), '0);

    @(posedge clk); #2 load(0, 1, 1);
    finish_batch("single_rd");
    @(posedge clk); #2 load(1, 0, 3);
    finish_batch("single_wr");
    @(posedge clk); #2 load(3, 3, 1);
    finish_batch("alternate");

    rdy_rand = 1;
    bub_en = 1;
    @(posedge clk); #2 load(1, 1, 10);
    finish_batch("overrun");
    for (int b = 0; b < 8; b++) begin
      @(posedge clk);
      #2 load($urandom_range(0, 4), $urandom_range(0, 4), 0);
      finish_batch("random");
    end

    // reset in the middle of a write payload
    rdy_rand = 0;
    @(posedge clk); #2 load(1, 1, 6);
    for (int c = 0; c < 200 && pw_q.size() > 4; c++) @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_no_pop", DW'({aw_rden_o, ar_rden_o, pw_rden_o}), '0);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    aw_q.delete();
    ar_q.delete();
    pw_q.delete();
    pw_start = 1;
    hide_cnt = 0;
    m_wr = 0;
    m_rd = 0;
    m_err = 0;
    m_rr = 0;
    refresh();
    @(negedge clk);
    check("midrst_valid", DW'(tlp_valid_o), '0);
    check("midrst_cnts", DW'({wr_tlp_cnt_o, rd_tlp_cnt_o, overrun_err_o}), '0);
    @(posedge clk); #2 load(2, 2, 2);
    finish_batch("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_tx_scheduler.md
Name: tlp_tx_scheduler

Overview:
Sits after the AW-header, AR-header and write-payload FIFOs in the PCIe TX path and reads from them. Arbitrates round-robin between write requests (MWr: header plus payload) and read requests (MRd: header only). Emits one TLP at a time as a beat stream with SOP/EOP and valid/ready handshake toward the TLP/link layer. Also keeps per-type TLP counters and a sticky payload-overrun error.

Parameters:
DATA_WIDTH, 256, output beat width and payload FIFO width; must be >= HDR_WIDTH
HDR_WIDTH, 128, header FIFO entry width (4DW header)
MAX_PAYLOAD_BEATS, 8, maximum payload beats per write TLP (256B MPS / 32B)
CNT_WIDTH, 16, width of the TLP statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
aw_empty_i  in  1  write-header FIFO empty
aw_rdata_i  in  HDR_WIDTH  write-header FIFO head entry
aw_rden_o  out  1  pop write-header FIFO
ar_empty_i  in  1  read-header FIFO empty
ar_rdata_i  in  HDR_WIDTH  read-header FIFO head entry
ar_rden_o  out  1  pop read-header FIFO
pw_empty_i  in  1  payload FIFO empty
pw_rdata_i  in  DATA_WIDTH  payload FIFO head entry
pw_last_i  in  1  head payload entry is the last beat of its burst
pw_rden_o  out  1  pop payload FIFO
tlp_valid_o  out  1  output beat valid
tlp_ready_i  in  1  downstream accepts beat
tlp_data_o  out  DATA_WIDTH  output beat
tlp_sop_o  out  1  first beat of TLP
tlp_eop_o  out  1  last beat of TLP
tlp_is_wr_o  out  1  current TLP is a write (MWr)
wr_tlp_cnt_o  out  CNT_WIDTH  completed write TLPs, wraps
rd_tlp_cnt_o  out  CNT_WIDTH  completed read TLPs, wraps
overrun_err_o  out  1  sticky: a payload burst exceeded MAX_PAYLOAD_BEATS

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- FIFO interface: all FIFOs are first-word-fall-through. rdata/last are valid whenever empty is low. Asserting rden for one cycle pops one entry. rden is never asserted while the matching empty is high.
- Handshake: a beat transfers on tlp_valid_o & tlp_ready_i. Once asserted, tlp_valid_o, tlp_data_o, sop, eop and is_wr stay stable until the transfer.
- Reset: state IDLE, rr_ptr=0 (write preferred), beat_cnt=0, counters=0, overrun_err_o=0. All rden=0, tlp_valid_o=0, sop=eop=is_wr=0, tlp_data_o=0.
- States: IDLE, WR_HDR, WR_DATA, RD_HDR, DRAIN.
- IDLE:
  - wr_req = !aw_empty_i & !pw_empty_i; rd_req = !ar_empty_i.
  - Both requesting: rr_ptr=0 -> WR_HDR, rr_ptr=1 -> RD_HDR. Only one requesting -> grant it.
  - On a grant, rr_ptr is set to the other type.
  - No output in IDLE, so there is a 1-cycle arbitration bubble between TLPs.
- WR_HDR: valid=1, sop=1, eop=0, is_wr=1, data = header zero-extended into the low HDR_WIDTH bits. On transfer: aw_rden_o=1, beat_cnt=0, go to WR_DATA.
- WR_DATA:
  - valid = !pw_empty_i; data = pw_rdata_i; sop=0; is_wr=1. An empty payload FIFO inserts bubbles without leaving the state.
  - eop = pw_last_i | (beat_cnt == MAX_PAYLOAD_BEATS-1).
  - On transfer: pw_rden_o=1, beat_cnt++.
  - If eop: wr_tlp_cnt++ and go to IDLE. If eop was forced (limit reached and !pw_last_i): set overrun_err_o and go to DRAIN instead.
- DRAIN: no output. Pop payload beats (pw_rden_o = !pw_empty_i) until a popped beat has pw_last_i=1, then go to IDLE.
- RD_HDR: valid=1, sop=1, eop=1, is_wr=0, data = read header zero-extended. On transfer: ar_rden_o=1, rd_tlp_cnt++, go to IDLE.
- Counters wrap modulo 2^CNT_WIDTH. overrun_err_o clears only on rst.
- rst asserted mid-TLP: everything returns to reset values on the next edge. No pops occur in the reset cycle; a partial TLP is abandoned.
- Simultaneous new requests while a TLP is in flight are not sampled until IDLE; no pre-emption.

Test Plan:
- Single read: one AR entry 0xA5..A5 -> after 1 IDLE cycle, one beat with sop=eop=1, is_wr=0, low 128b=0xA5..A5, upper bits 0. ar_rden pulses once, rd_tlp_cnt=1.
- Single write, 3 payload beats (last on beat 3), ready always high -> 4 beats: header (sop) then D0, D1, D2 (eop on D2). aw_rden 1 pulse, pw_rden 3 pulses, wr_tlp_cnt=1.
- Both queues hold 3 requests (1-beat writes) -> output order W, R, W, R, W, R starting with write after reset. Final wr_tlp_cnt=3, rd_tlp_cnt=3.
- Backpressure: tlp_ready_i low for 5 cycles mid-write -> valid, data and eop held constant; no extra pops; beat sequence unchanged.
- Payload bubble: pw_empty_i high for 4 cycles between D0 and D1 -> valid low during the gap; state stays WR_DATA; a pending read is not serviced until the write completes.
- Overrun, MAX_PAYLOAD_BEATS=8, burst of 10 beats -> eop forced on beat 8, overrun_err_o=1. Beats 9 and 10 are popped with no output. Next TLP starts cleanly.
- rst pulsed during WR_DATA -> the next cycle shows valid=0, counters=0, state IDLE.
